div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 137 +++++++++++++
 tb/tb_div_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: two-requester round-robin front end for one shared divider.
// Accepts at most one operation per cycle, registers its operands towards the
// divider, and tracks a {valid, id, dz} tag through a LAT+1 stage pipeline so
// each quotient comes back tagged with its requester, in issue order.
module div_arbiter #(
    parameter int M   = 26,
    parameter int N   = 14,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [M-1:0] req0_dividend,
    input  logic [N-1:0] req0_divisor,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [M-1:0] req1_dividend,
    input  logic [N-1:0] req1_divisor,
    output logic [M-1:0] div_dividend,
    output logic [N-1:0] div_divisor,
    input  logic [M-1:0] div_quotient,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [M-1:0] resp_quotient,
    output logic         resp_dz,
    output logic [3:0]   inflight
);

    // The 4-bit inflight counter holds at most LAT+1, so LAT is capped at 14.
    if (LAT < 0 || LAT > 14) begin : g_lat_check
        $error("div_arbiter: LAT must be in the range 0..14");
    end

    // Requester that wins when both are valid (the one not granted last).
    logic         prio;

    logic         grant0;
    logic         grant1;
    logic         handshake;
    logic         grant_id;
    logic [M-1:0] sel_dividend;
    logic [N-1:0] sel_divisor;
    logic         sel_dz;

    // Tag pipeline; index 0 is loaded on the accepting edge, index LAT is the
    // entry whose quotient is on div_quotient right now.
    logic [LAT:0] tag_valid;
    logic [LAT:0] tag_id;
    logic [LAT:0] tag_dz;

    logic         tail_valid;
    logic         tail_id;
    logic         tail_dz;

    // Round-robin grant and operand mux; ready is held low during reset.
    always_comb begin
        grant0       = rst_n & req0_valid & (~req1_valid | ~prio);
        grant1       = rst_n & req1_valid & (~req0_valid | prio);
        handshake    = grant0 | grant1;
        grant_id     = grant1;
        sel_dividend = grant1 ? req1_dividend : req0_dividend;
        sel_divisor  = grant1 ? req1_divisor  : req0_divisor;
        sel_dz       = (sel_divisor == '0);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign tail_valid = tag_valid[LAT];
    assign tail_id    = tag_id[LAT];
    assign tail_dz    = tag_dz[LAT];

    // Priority pointer moves only when an operation is actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (handshake) begin
            prio <= grant0;
        end
    end

    // Operand registers feeding the divider, held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (handshake) begin
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
        end
    end

    // Tag shift register; the cast drops the oldest entry and also covers LAT=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
            tag_dz    <= '0;
        end else begin
            tag_valid <= (LAT+1)'({tag_valid, handshake});
            tag_id    <= (LAT+1)'({tag_id, grant_id});
            tag_dz    <= (LAT+1)'({tag_dz, sel_dz});
        end
    end

    // Response registers; divide-by-zero forces an all-ones quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_quotient <= '0;
            resp_dz       <= 1'b0;
        end else begin
            resp_valid <= tail_valid;
            resp_dz    <= tail_valid & tail_dz;
            if (tail_valid) begin
                resp_id       <= tail_id;
                resp_quotient <= tail_dz ? '1 : div_quotient;
            end
        end
    end

    // Count of accepted operations whose tag has not yet left the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 4'd0;
        end else begin
            case ({handshake, tail_valid})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: drives one LAT=0 and one LAT=3 div_arbiter with the same
// requests, each behind its own model divider, and checks both against a
// behavioural model of the arbitration and response timing.
module tb_div_arbiter;

    localparam int M = 26;
    localparam int N = 14;
    localparam logic [M-1:0] JUNK = 26'h0ABCDEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid;
    logic [M-1:0] req0_dividend;
    logic [N-1:0] req0_divisor;
    logic         req1_valid;
    logic [M-1:0] req1_dividend;
    logic [N-1:0] req1_divisor;

    // Index 0 = LAT 0 instance, index 1 = LAT 3 instance.
    logic         rdy0 [2];
    logic         rdy1 [2];
    logic         rv   [2];
    logic         rid  [2];
    logic         rdz  [2];
    logic [M-1:0] dd   [2];
    logic [N-1:0] dv   [2];
    logic [M-1:0] rq   [2];
    logic [M-1:0] qin  [2];
    logic [3:0]   infl [2];
    logic [M-1:0] pipe3 [3];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int           k;
        logic         id;
        logic [M-1:0] q;
        logic         dz;
    } op_t;

    op_t          issued[$];
    op_t          m_op;
    op_t          m_hit;
    logic         last_m;
    logic         m_g0;
    logic         m_g1;
    logic         m_found;
    int           m_cnt;
    int           m_due;
    logic [M-1:0] exp_dd;
    logic [N-1:0] exp_dv;
    logic [M-1:0] exp_rq [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_arbiter #(.M(M), .N(N), .LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[0]),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(rdy1[0]),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .div_dividend(dd[0]), .div_divisor(dv[0]), .div_quotient(qin[0]),
        .resp_valid(rv[0]), .resp_id(rid[0]), .resp_quotient(rq[0]),
        .resp_dz(rdz[0]), .inflight(infl[0])
    );

    div_arbiter #(.M(M), .N(N), .LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[1]),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(rdy1[1]),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .div_dividend(dd[1]), .div_divisor(dv[1]), .div_quotient(qin[1]),
        .resp_valid(rv[1]), .resp_id(rid[1]), .resp_quotient(rq[1]),
        .resp_dz(rdz[1]), .inflight(infl[1])
    );

    // Model dividers: combinational for LAT 0, three-stage pipeline for LAT 3.
    // A zero divisor yields junk so the forced all-ones result is observable.
    assign qin[0] = (dv[0] == '0) ? JUNK : dd[0] / {{(M-N){1'b0}}, dv[0]};

    always @(posedge clk) begin
        pipe3[0] <= (dv[1] == '0) ? JUNK : dd[1] / {{(M-N){1'b0}}, dv[1]};
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign qin[1] = pipe3[2];

    function automatic int latOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic checkOutput(input string name, input int d,
                               input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d @cyc %0d: got 0x%0h, expected 0x%0h",
                     name, d, cyc, actual, required);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [M-1:0] a0, input logic [N-1:0] b0,
                                 input logic v1, input logic [M-1:0] a1, input logic [N-1:0] b1);
        req0_valid    = v0;
        req0_dividend = a0;
        req0_divisor  = b0;
        req1_valid    = v1;
        req1_dividend = a1;
        req1_divisor  = b1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (3) nextCycle();
        rst_n = 1'b1;
    endtask

    // Behavioural model: every accepted op is logged with its accept edge k;
    // an instance with latency L answers it in cycle k+L+1 and counts it as
    // in flight for cycles k .. k+L.
    always @(negedge clk) begin
        if (!rst_n) begin
            issued.delete();
            last_m    = 1'b1;
            exp_dd    = '0;
            exp_dv    = '0;
            exp_rq[0] = '0;
            exp_rq[1] = '0;
            for (int d = 0; d < 2; d++) begin
                checkOutput("rst_ready0",   d, 32'(rdy0[d]), 32'd0);
                checkOutput("rst_ready1",   d, 32'(rdy1[d]), 32'd0);
                checkOutput("rst_dividend", d, 32'(dd[d]),   32'd0);
                checkOutput("rst_divisor",  d, 32'(dv[d]),   32'd0);
                checkOutput("rst_valid",    d, 32'(rv[d]),   32'd0);
                checkOutput("rst_id",       d, 32'(rid[d]),  32'd0);
                checkOutput("rst_quotient", d, 32'(rq[d]),   32'd0);
                checkOutput("rst_dz",       d, 32'(rdz[d]),  32'd0);
                checkOutput("rst_inflight", d, 32'(infl[d]), 32'd0);
            end
        end else begin
            m_g0 = req0_valid && (!req1_valid || last_m);
            m_g1 = req1_valid && !m_g0;
            for (int d = 0; d < 2; d++) begin
                checkOutput("ready0",   d, 32'(rdy0[d]), 32'(m_g0));
                checkOutput("ready1",   d, 32'(rdy1[d]), 32'(m_g1));
                checkOutput("dividend", d, 32'(dd[d]),   32'(exp_dd));
                checkOutput("divisor",  d, 32'(dv[d]),   32'(exp_dv));
                m_found = 1'b0;
                m_cnt   = 0;
                foreach (issued[i]) begin
                    m_due = issued[i].k + latOf(d) + 1;
                    if (m_due == cyc) begin
                        m_found = 1'b1;
                        m_hit   = issued[i];
                    end
                    if (issued[i].k <= cyc && cyc < m_due) m_cnt++;
                end
                checkOutput("resp_valid", d, 32'(rv[d]), 32'(m_found));
                if (m_found) begin
                    exp_rq[d] = m_hit.q;
                    checkOutput("resp_id", d, 32'(rid[d]), 32'(m_hit.id));
                    checkOutput("resp_dz", d, 32'(rdz[d]), 32'(m_hit.dz));
                end else begin
                    checkOutput("resp_dz_idle", d, 32'(rdz[d]), 32'd0);
                end
                checkOutput("resp_quotient", d, 32'(rq[d]), 32'(exp_rq[d]));
                checkOutput("inflight", d, 32'(infl[d]), 32'(m_cnt));
            end
            if (m_g0 || m_g1) begin
                m_op.k  = cyc + 1;
                m_op.id = m_g1;
                exp_dd  = m_g1 ? req1_dividend : req0_dividend;
                exp_dv  = m_g1 ? req1_divisor  : req0_divisor;
                m_op.dz = (exp_dv == '0);
                m_op.q  = m_op.dz ? {M{1'b1}} : exp_dd / {{(M-N){1'b0}}, exp_dv};
                issued.push_back(m_op);
                last_m  = m_g1;
            end
            while (issued.size() > 0 && issued[0].k + 8 < cyc) void'(issued.pop_front());
        end
    end

    // Directed scenarios with hand-computed expectations, then random traffic.
    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        doReset();

        // Single req0 op 0x3FFC000 / 3 = 0x1554000.
        applyStimulus(1'b1, 26'h3FFC000, 14'd3, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("p1_ready0_now", 0, 32'(rdy0[0]), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("p1_no_resp_yet", 0, 32'(rv[0]), 32'd0);
        checkOutput("p1_inflight", 0, 32'(infl[0]), 32'd1);
        checkOutput("p1_div_dividend", 0, 32'(dd[0]), 32'h3FFC000);
        nextCycle();
        @(negedge clk);
        checkOutput("p1_resp_valid", 0, 32'(rv[0]), 32'd1);
        checkOutput("p1_resp_id", 0, 32'(rid[0]), 32'd0);
        checkOutput("p1_quotient", 0, 32'(rq[0]), 32'h1554000);
        checkOutput("p1_dz", 0, 32'(rdz[0]), 32'd0);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("p1_lat3_valid", 1, 32'(rv[1]), 32'd1);
        checkOutput("p1_lat3_quotient", 1, 32'(rq[1]), 32'h1554000);
        repeat (2) nextCycle();

        // Both valid for six cycles straight after reset: grants alternate.
        doReset();
        for (int i = 0; i < 8; i++) begin
            if (i < 6)
                applyStimulus(1'b1, 26'($urandom), 14'($urandom), 1'b1, 26'($urandom), 14'($urandom));
            else
                applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
            @(negedge clk);
            if (i < 6) begin
                checkOutput("p2_grant0", 0, 32'(rdy0[0]), 32'(i % 2 == 0));
                checkOutput("p2_grant1", 0, 32'(rdy1[0]), 32'(i % 2 == 1));
            end
            if (i >= 2) begin
                checkOutput("p2_resp_valid", 0, 32'(rv[0]), 32'd1);
                checkOutput("p2_resp_order", 0, 32'(rid[0]), 32'((i - 2) % 2));
            end
            nextCycle();
        end
        repeat (6) nextCycle();

        // req1 divides by zero: all-ones quotient, dz flagged.
        applyStimulus(1'b0, '0, '0, 1'b1, 26'h0000123, 14'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        nextCycle();
        @(negedge clk);
        checkOutput("p3_resp_valid", 0, 32'(rv[0]), 32'd1);
        checkOutput("p3_resp_id", 0, 32'(rid[0]), 32'd1);
        checkOutput("p3_dz", 0, 32'(rdz[0]), 32'd1);
        checkOutput("p3_quotient", 0, 32'(rq[0]), 32'h3FFFFFF);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("p3_lat3_dz", 1, 32'(rdz[1]), 32'd1);
        checkOutput("p3_lat3_quotient", 1, 32'(rq[1]), 32'h3FFFFFF);
        repeat (4) nextCycle();

        // Three back-to-back req0 issues into the LAT 3 instance.
        applyStimulus(1'b1, 26'd1000, 14'd10, 1'b0, '0, '0);
        nextCycle();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      applyStimulus(1'b1, 26'd5000, 14'd7, 1'b0, '0, '0);
            else if (i == 1) applyStimulus(1'b1, 26'd99, 14'd100, 1'b0, '0, '0);
            else             applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
            @(negedge clk);
            checkOutput("p4_resp_valid", 1, 32'(rv[1]), 32'(i >= 4 && i <= 6));
            if (i < 3) checkOutput("p4_inflight", 1, 32'(infl[1]), 32'(i + 1));
            if (i == 7) checkOutput("p4_inflight_end", 1, 32'(infl[1]), 32'd0);
            nextCycle();
        end
        repeat (2) nextCycle();

        // Reset two cycles after an accept in LAT 3: everything clears at once.
        applyStimulus(1'b1, 26'h2000000, 14'd7, 1'b0, '0, '0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) nextCycle();
        rst_n = 1'b0;
        applyStimulus(1'b1, 26'h155, 14'd5, 1'b1, 26'h2AA, 14'd3);
        #1;
        checkOutput("p5_dividend", 1, 32'(dd[1]), 32'd0);
        checkOutput("p5_divisor", 1, 32'(dv[1]), 32'd0);
        checkOutput("p5_inflight", 1, 32'(infl[1]), 32'd0);
        checkOutput("p5_quotient", 1, 32'(rq[1]), 32'd0);
        checkOutput("p5_ready0", 1, 32'(rdy0[1]), 32'd0);
        checkOutput("p5_ready1", 1, 32'(rdy1[1]), 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        nextCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("p5_no_ghost", 1, 32'(rv[1]), 32'd0);
            nextCycle();
        end

        // Only req1 valid while the pointer favours req0: granted immediately.
        applyStimulus(1'b0, '0, '0, 1'b1, 26'h64, 14'd4);
        @(negedge clk);
        checkOutput("p6_ready1_after_reset", 0, 32'(rdy1[0]), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 26'hC8, 14'd8);
        @(negedge clk);
        checkOutput("p6_ready1_again", 0, 32'(rdy1[0]), 32'd1);
        checkOutput("p6_ready1_again", 1, 32'(rdy1[1]), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (6) nextCycle();

        // Random traffic with an occasional zero divisor and one mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) doReset();
            applyStimulus($urandom_range(0, 9) < 6, 26'($urandom),
                          ($urandom_range(0, 7) == 0) ? 14'd0 : 14'($urandom),
                          $urandom_range(0, 9) < 6, 26'($urandom),
                          ($urandom_range(0, 7) == 0) ? 14'd0 : 14'($urandom));
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (10) nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
